axi_mmio_stream_hub: RTL and testbench

AXI_MMIO_STREAM_HUB -- requirements
Module: axi_mmio_stream_hub

---
 rtl/axi_mmio_stream_hub_if.sv | 64 ++++++
 rtl/axi_mmio_stream_hub.sv | 224 ++++++++++++++++++++++
 tb/tb_axi_mmio_stream_hub.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mmio_stream_hub_if.sv
// AXI4 slave bus bundle for the MMIO stream hub: AW/W/B write path and AR/R read path.
interface axi_mmio_stream_hub_if #(
  parameter int ID_W = 4
) ();
  logic            aw_valid;
  logic            aw_ready;
  logic [ID_W-1:0] aw_id;
  logic [30:0]     aw_addr;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size;
  logic [1:0]      aw_burst;

  logic            w_valid;
  logic            w_ready;
  logic [63:0]     w_data;
  logic [7:0]      w_strb;
  logic            w_last;

  logic            b_valid;
  logic            b_ready;
  logic [ID_W-1:0] b_id;
  logic [1:0]      b_resp;

  logic            ar_valid;
  logic            ar_ready;
  logic [ID_W-1:0] ar_id;
  logic [30:0]     ar_addr;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size;
  logic [1:0]      ar_burst;

  logic            r_valid;
  logic            r_ready;
  logic [ID_W-1:0] r_id;
  logic [63:0]     r_data;
  logic [1:0]      r_resp;
  logic            r_last;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );
endinterface

// File: rtl/axi_mmio_stream_hub.sv
// AXI4 MMIO to per-channel byte stream hub with FWFT TX FIFOs and STATUS readback.
// Optional pop counters in STATUS[63:32] are built when STREAM_HUB_STATS_EN is defined.
//
// state  | meaning
// W_IDLE | waiting for AW
// W_DATA | accepting W beats until w_last
// W_RESP | holding B until b_ready
// R_IDLE | waiting for AR
// R_DATA | holding single R beat until r_ready
module axi_mmio_stream_hub #(
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int ID_W       = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  axi_mmio_stream_hub_if.slave    io_axi4_0,
  output logic [8*NUM_CH-1:0]     m_axis_tdata,
  output logic [NUM_CH-1:0]       m_axis_tvalid,
  input  logic [NUM_CH-1:0]       m_axis_tready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_DATA} rstate_e;

  wstate_e r_wstate, w_wstate_nxt;
  rstate_e r_rstate, w_rstate_nxt;

  logic [7:0]    r_mem  [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0] r_wptr [NUM_CH];
  logic [PW-1:0] r_rptr [NUM_CH];
  logic [PW-1:0] w_occ  [NUM_CH];
  logic [31:0]   w_stat [NUM_CH];
  logic [NUM_CH-1:0] w_empty, w_full, w_pop, w_push;

  logic [ID_W-1:0] r_aw_id, r_ar_id;
  logic [3:0]      r_aw_ch;
  logic            r_aw_reg, r_aw_len_nz;
  logic [1:0]      r_b_resp, r_r_resp, w_r_resp;
  logic [63:0]     r_r_data, w_r_data, w_rd_status;
  logic            w_aw_hs, w_ar_hs, w_wbeat, w_wready, w_aw_mapped, w_wr_push_ok, w_tgt_block;
  logic [3:0]      w_ar_ch;
  logic            w_unused;

  assign w_unused = ^{io_axi4_0.aw_size, io_axi4_0.aw_burst, io_axi4_0.aw_addr[30:8],
                      io_axi4_0.aw_addr[2:0], io_axi4_0.ar_size, io_axi4_0.ar_burst,
                      io_axi4_0.ar_addr[30:8], io_axi4_0.ar_addr[2:0],
                      io_axi4_0.w_data[63:8], io_axi4_0.w_strb[7:1]};

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_occ[c]   = r_wptr[c] - r_rptr[c];
      w_empty[c] = (r_wptr[c] == r_rptr[c]);
      w_full[c]  = (r_wptr[c][AW-1:0] == r_rptr[c][AW-1:0]) && (r_wptr[c][AW] != r_rptr[c][AW]);
      w_pop[c]   = !w_empty[c] && m_axis_tready[c];
      m_axis_tvalid[c]       = reset_n && !w_empty[c];
      m_axis_tdata[8*c +: 8] = (reset_n && !w_empty[c]) ? r_mem[c][r_rptr[c][AW-1:0]] : 8'h00;
    end
  end

  assign w_aw_mapped  = ({28'd0, r_aw_ch} < 32'(NUM_CH));
  assign w_wr_push_ok = !r_aw_len_nz && !r_aw_reg && w_aw_mapped;

  // A full target only stalls if nothing drains this cycle; push and pop may share the edge.
  always_comb begin
    w_tgt_block = 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      if (r_aw_ch == 4'(c)) w_tgt_block = w_full[c] && !w_pop[c];
  end

  always_comb begin
    w_wstate_nxt       = r_wstate;
    io_axi4_0.aw_ready = 1'b0;
    io_axi4_0.b_valid  = 1'b0;
    w_wready           = 1'b0;
    w_aw_hs            = 1'b0;
    w_wbeat            = 1'b0;
    if (reset_n) begin
      case (r_wstate)
        W_IDLE: begin
          io_axi4_0.aw_ready = 1'b1;
          w_aw_hs            = io_axi4_0.aw_valid;
          if (io_axi4_0.aw_valid) w_wstate_nxt = W_DATA;
        end
        W_DATA: begin
          w_wready = !(w_wr_push_ok && w_tgt_block);
          w_wbeat  = io_axi4_0.w_valid && w_wready;
          if (w_wbeat && io_axi4_0.w_last) w_wstate_nxt = W_RESP;
        end
        W_RESP: begin
          io_axi4_0.b_valid = 1'b1;
          if (io_axi4_0.b_ready) w_wstate_nxt = W_IDLE;
        end
        default: w_wstate_nxt = W_IDLE;
      endcase
    end
  end

  assign io_axi4_0.w_ready = w_wready;
  assign io_axi4_0.b_id    = r_aw_id;
  assign io_axi4_0.b_resp  = reset_n ? r_b_resp : 2'b00;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_push[c] = w_wbeat && w_wr_push_ok && io_axi4_0.w_strb[0] && (r_aw_ch == 4'(c));
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_wstate <= W_IDLE;
    else          r_wstate <= w_wstate_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_aw_id     <= '0;
      r_aw_ch     <= '0;
      r_aw_reg    <= 1'b0;
      r_aw_len_nz <= 1'b0;
      r_b_resp    <= 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_aw_id     <= io_axi4_0.aw_id;
        r_aw_ch     <= io_axi4_0.aw_addr[7:4];
        r_aw_reg    <= io_axi4_0.aw_addr[3];
        r_aw_len_nz <= |io_axi4_0.aw_len;
      end
      if (w_wbeat && io_axi4_0.w_last)
        r_b_resp <= r_aw_len_nz ? 2'b10 : (!w_aw_mapped ? 2'b11 : 2'b00);
    end
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++)
      if (w_push[c]) r_mem[c][r_wptr[c][AW-1:0]] <= io_axi4_0.w_data[7:0];
  end

  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!reset_n) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
      end else begin
        if (w_push[c]) r_wptr[c] <= r_wptr[c] + PW'(1);
        if (w_pop[c])  r_rptr[c] <= r_rptr[c] + PW'(1);
      end
    end
  end

`ifdef STREAM_HUB_STATS_EN
  logic [31:0] r_stat [NUM_CH];
  always_ff @(posedge clock) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!reset_n)      r_stat[c] <= 32'd0;
      else if (w_pop[c]) r_stat[c] <= r_stat[c] + 32'd1;
    end
  end
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) w_stat[c] = r_stat[c];
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) w_stat[c] = 32'd0;
  end
`endif

  // STATUS is captured at the AR handshake, so it reflects pre-edge FIFO state.
  always_comb begin
    w_ar_ch     = io_axi4_0.ar_addr[7:4];
    w_rd_status = 64'd0;
    for (int c = 0; c < NUM_CH; c++)
      if (w_ar_ch == 4'(c))
        w_rd_status = {w_stat[c], 23'd0, 7'(w_occ[c]), w_full[c], w_empty[c]};
    w_r_resp = 2'b00;
    w_r_data = 64'd0;
    if (|io_axi4_0.ar_len)                     w_r_resp = 2'b10;
    else if ({28'd0, w_ar_ch} >= 32'(NUM_CH))  w_r_resp = 2'b11;
    else if (io_axi4_0.ar_addr[3])             w_r_data = w_rd_status;
  end

  always_comb begin
    w_rstate_nxt       = r_rstate;
    io_axi4_0.ar_ready = 1'b0;
    io_axi4_0.r_valid  = 1'b0;
    w_ar_hs            = 1'b0;
    if (reset_n) begin
      case (r_rstate)
        R_IDLE: begin
          io_axi4_0.ar_ready = 1'b1;
          w_ar_hs            = io_axi4_0.ar_valid;
          if (io_axi4_0.ar_valid) w_rstate_nxt = R_DATA;
        end
        R_DATA: begin
          io_axi4_0.r_valid = 1'b1;
          if (io_axi4_0.r_ready) w_rstate_nxt = R_IDLE;
        end
        default: w_rstate_nxt = R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) r_rstate <= R_IDLE;
    else          r_rstate <= w_rstate_nxt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ar_id  <= '0;
      r_r_resp <= 2'b00;
      r_r_data <= 64'd0;
    end else if (w_ar_hs) begin
      r_ar_id  <= io_axi4_0.ar_id;
      r_r_resp <= w_r_resp;
      r_r_data <= w_r_data;
    end
  end

  assign io_axi4_0.r_id   = r_ar_id;
  assign io_axi4_0.r_resp = reset_n ? r_r_resp : 2'b00;
  assign io_axi4_0.r_data = reset_n ? r_r_data : 64'd0;
  assign io_axi4_0.r_last = 1'b1;
endmodule

// File: tb/tb_axi_mmio_stream_hub.sv
// Directed bench for axi_mmio_stream_hub (NUM_CH=2, FIFO_DEPTH=16); STATUS[63:32]
// expectations follow STREAM_HUB_STATS_EN.
module tb_axi_mmio_stream_hub;
  localparam int LIM = 60;
`ifdef STREAM_HUB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] m_axis_tdata;
  logic [1:0]  m_axis_tvalid;
  logic [1:0]  m_axis_tready = 2'b00;
  int          checks = 0;
  int          errors = 0;

  axi_mmio_stream_hub_if #(.ID_W(4)) axi ();

  axi_mmio_stream_hub #(.NUM_CH(2), .FIFO_DEPTH(16), .ID_W(4)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .io_axi4_0     (axi.slave),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge clock);
    axi.aw_valid = 1'b1; axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len;
    while (axi.aw_ready !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
    check("aw_wait", 64'(n < LIM), 64'd1);
    @(posedge clock); #1;
    axi.aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [7:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    @(negedge clock);
    axi.w_valid = 1'b1; axi.w_data = {56'hDEAD_BEEF_CAFE_00, data}; axi.w_strb = strb; axi.w_last = last;
    while (axi.w_ready !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
    check("w_wait", 64'(n < LIM), 64'd1);
    @(posedge clock); #1;
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
  endtask

  task automatic b_recv(output logic [1:0] resp, output logic [3:0] id);
    int n = 0;
    @(negedge clock);
    axi.b_ready = 1'b1;
    while (axi.b_valid !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
    check("b_wait", 64'(n < LIM), 64'd1);
    resp = axi.b_resp; id = axi.b_id;
    @(posedge clock); #1;
    axi.b_ready = 1'b0;
  endtask

  task automatic ar_send(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] len);
    int n = 0;
    @(negedge clock);
    axi.ar_valid = 1'b1; axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
    while (axi.ar_ready !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
    check("ar_wait", 64'(n < LIM), 64'd1);
    @(posedge clock); #1;
    axi.ar_valid = 1'b0;
  endtask

  task automatic r_recv(output logic [63:0] data, output logic [1:0] resp,
                        output logic [3:0] id, output logic last);
    int n = 0;
    @(negedge clock);
    axi.r_ready = 1'b1;
    while (axi.r_valid !== 1'b1 && n < LIM) begin @(negedge clock); n++; end
    check("r_wait", 64'(n < LIM), 64'd1);
    data = axi.r_data; resp = axi.r_resp; id = axi.r_id; last = axi.r_last;
    @(posedge clock); #1;
    axi.r_ready = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [30:0] addr, input logic [7:0] data,
                          output logic [1:0] resp, output logic [3:0] bid);
    aw_send(id, addr, 8'd0);
    w_send(data, 8'h01, 1'b1);
    b_recv(resp, bid);
  endtask

  task automatic do_read(input logic [3:0] id, input logic [30:0] addr,
                         output logic [63:0] data, output logic [1:0] resp,
                         output logic [3:0] rid, output logic last);
    ar_send(id, addr, 8'd0);
    r_recv(data, resp, rid, last);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [3:0]  id;
    logic [63:0] data;
    logic        last;
    logic [31:0] st0, st1;

    axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 3'd0; axi.aw_burst = 2'd1;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.b_ready = 0;
    axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 3'd0; axi.ar_burst = 2'd1;
    axi.r_ready = 0;
    st0 = STATS ? 32'd1 : 32'd0;
    st1 = STATS ? 32'd5 : 32'd0;

    // reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_aw_ready", 64'(axi.aw_ready), 64'd0);
    check("rst_ar_ready", 64'(axi.ar_ready), 64'd0);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    reset_n = 1'b1;
    @(negedge clock);
    check("post_rst_ready", 64'({axi.aw_ready, axi.ar_ready}), 64'd3);

    // single byte to ch0 with sink ready
    m_axis_tready = 2'b01;
    aw_send(4'd5, 31'h00, 8'd0);
    w_send(8'h41, 8'h01, 1'b1);
    @(negedge clock);
    check("ch0_tvalid", 64'(m_axis_tvalid[0]), 64'd1);
    check("ch0_tdata", 64'(m_axis_tdata[7:0]), 64'h41);
    @(negedge clock);
    check("ch0_drained", 64'(m_axis_tvalid[0]), 64'd0);
    b_recv(resp, id);
    check("b_okay", 64'(resp), 64'd0);
    check("b_id", 64'(id), 64'd5);

    // unmapped channel 2
    do_write(4'd7, 31'h20, 8'hAB, resp, id);
    check("unmap_b_resp", 64'(resp), 64'd3);
    check("unmap_b_id", 64'(id), 64'd7);
    do_read(4'd9, 31'h28, data, resp, id, last);
    check("unmap_r_resp", 64'(resp), 64'd3);
    check("unmap_r_data", data, 64'd0);
    check("unmap_r_id", 64'(id), 64'd9);
    check("unmap_no_push", 64'(m_axis_tvalid), 64'd0);

    // burst writes and reads are rejected
    m_axis_tready = 2'b00;
    aw_send(4'd3, 31'h00, 8'd3);
    for (int i = 0; i < 3; i++) w_send(8'h55 + 8'(i), 8'h01, 1'b0);
    @(negedge clock);
    check("burst_no_early_b", 64'(axi.b_valid), 64'd0);
    w_send(8'h58, 8'h01, 1'b1);
    b_recv(resp, id);
    check("burst_b_resp", 64'(resp), 64'd2);
    check("burst_b_id", 64'(id), 64'd3);
    check("burst_no_push", 64'(m_axis_tvalid), 64'd0);
    ar_send(4'd6, 31'h08, 8'd2);
    r_recv(data, resp, id, last);
    check("burst_r_resp", 64'(resp), 64'd2);
    check("burst_r_data", data, 64'd0);
    check("burst_r_last", 64'(last), 64'd1);
    check("burst_r_id", 64'(id), 64'd6);

    // DATA read returns zero, STATUS write is a no-op
    do_read(4'd1, 31'h00, data, resp, id, last);
    check("data_rd_zero", data, 64'd0);
    check("data_rd_resp", 64'(resp), 64'd0);
    do_write(4'd2, 31'h08, 8'h99, resp, id);
    check("status_wr_resp", 64'(resp), 64'd0);
    check("status_wr_no_push", 64'(m_axis_tvalid), 64'd0);

    // simultaneous STATUS read and push at occupancy 3
    do_write(4'd1, 31'h00, 8'h11, resp, id);
    do_write(4'd1, 31'h00, 8'h22, resp, id);
    do_write(4'd1, 31'h00, 8'h33, resp, id);
    aw_send(4'd1, 31'h00, 8'd0);
    @(negedge clock);
    axi.w_valid = 1'b1; axi.w_data = 64'h44; axi.w_strb = 8'h01; axi.w_last = 1'b1;
    axi.ar_valid = 1'b1; axi.ar_id = 4'd2; axi.ar_addr = 31'h08; axi.ar_len = 8'd0;
    check("sim_both_ready", 64'({axi.ar_ready, axi.w_ready}), 64'd3);
    @(posedge clock); #1;
    axi.w_valid = 1'b0; axi.w_last = 1'b0; axi.ar_valid = 1'b0;
    r_recv(data, resp, id, last);
    check("sim_status_occ3", data, {st0, 32'h0000_000C});
    b_recv(resp, id);
    check("sim_b_resp", 64'(resp), 64'd0);
    do_read(4'd2, 31'h08, data, resp, id, last);
    check("after_status_occ4", data, {st0, 32'h0000_0010});
    check("ch0_head", 64'(m_axis_tdata[7:0]), 64'h11);

    // fill ch1, 17th beat backpressured until one pop
    for (int i = 0; i < 16; i++) do_write(4'd4, 31'h10, 8'h80 + 8'(i), resp, id);
    check("fill_last_resp", 64'(resp), 64'd0);
    aw_send(4'd4, 31'h10, 8'd0);
    @(negedge clock);
    axi.w_valid = 1'b1; axi.w_data = 64'h90; axi.w_strb = 8'h01; axi.w_last = 1'b1;
    #1;
    check("full_w_ready0", 64'(axi.w_ready), 64'd0);
    repeat (3) @(negedge clock);
    check("full_w_ready0_hold", 64'(axi.w_ready), 64'd0);
    m_axis_tready = 2'b10;
    #1;
    check("full_pop_w_ready1", 64'(axi.w_ready), 64'd1);
    @(posedge clock); #1;
    m_axis_tready = 2'b00;
    axi.w_valid = 1'b0; axi.w_last = 1'b0;
    b_recv(resp, id);
    check("full_b_resp", 64'(resp), 64'd0);
    check("ch1_head", 64'(m_axis_tdata[15:8]), 64'h81);
    do_read(4'd4, 31'h18, data, resp, id, last);
    check("ch1_status_full", data, {st0, 32'h0000_0042});

    // reset mid-state flushes FIFOs, then stats and drain on ch0
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    check("rst2_outputs", 64'({m_axis_tvalid, m_axis_tdata}), 64'd0);
    check("rst2_ready", 64'({axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid}), 64'd0);
    reset_n = 1'b1;
    for (int i = 1; i <= 5; i++) do_write(4'd0, 31'h00, 8'(i), resp, id);
    do_read(4'd0, 31'h08, data, resp, id, last);
    check("occ5_status", data, 64'h0000_0000_0000_0014);
    @(negedge clock);
    m_axis_tready = 2'b01;
    for (int k = 1; k <= 5; k++) begin
      check("drain_tdata", 64'({m_axis_tvalid[0], m_axis_tdata[7:0]}), 64'({1'b1, 8'(k)}));
      @(negedge clock);
    end
    check("drain_empty", 64'(m_axis_tvalid[0]), 64'd0);
    do_read(4'd0, 31'h08, data, resp, id, last);
    check("stats5_status", data, {st1, 32'h0000_0001});
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    do_read(4'd0, 31'h08, data, resp, id, last);
    check("stats_cleared", data, 64'h0000_0000_0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
